// File: rtl/if_axis_mc_pkg.sv
// Shared register map, bit positions and offset decoder for the multi-channel
// AXI-stream to CPU bridge.
package if_axis_mc_pkg;

  localparam logic [7:0] OffStatus  = 8'h00;
  localparam logic [7:0] OffIrqMask = 8'h04;
  localparam logic [7:0] OffClear   = 8'h08;
  localparam logic [7:0] OffChBase  = 8'h10;
  localparam logic [7:0] ChStride   = 8'd8;

  localparam int unsigned ValidBit = 31;
  localparam int unsigned FlagBit  = 24;
  localparam int unsigned OvfBase  = 8;

  typedef enum logic [2:0] {
    RegNone,
    RegStatus,
    RegMask,
    RegClear,
    RegData,
    RegLevel
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [4:0] ch;
  } reg_dec_t;

  // Channel range is not checked here; the top ignores channels it does not have.
  function automatic reg_dec_t decode_off(logic [7:0] off);
    reg_dec_t   dec;
    logic [7:0] rel;
    logic [7:0] idx;
    dec.sel = RegNone;
    dec.ch  = '0;
    rel     = off - OffChBase;
    idx     = rel / ChStride;
    if (off == OffStatus) begin
      dec.sel = RegStatus;
    end else if (off == OffIrqMask) begin
      dec.sel = RegMask;
    end else if (off == OffClear) begin
      dec.sel = RegClear;
    end else if (off >= OffChBase) begin
      dec.ch = idx[4:0];
      if (rel[2:0] == 3'd0) begin
        dec.sel = RegData;
      end else if (rel[2:0] == 3'd4) begin
        dec.sel = RegLevel;
      end
    end
    return dec;
  endfunction

endpackage

// File: rtl/axis_fifo_flag.sv
// Per-channel synchronous FIFO with flush, drop-on-full and sticky overflow.
module axis_fifo_flag #(
  parameter int unsigned Width        = 9,
  parameter int unsigned Depth        = 16,
  parameter bit          DropWhenFull = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [Width-1:0]         in_data,
  output logic                     ready,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic [Width-1:0]         head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rdy_q;
  logic             accept, do_push, do_pop, drop;

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);
  assign ready = DropWhenFull ? rdy_q : (rdy_q & ~full);
  assign head  = mem[rd_q];
  assign count = cnt_q;
  assign ovf   = ovf_q;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop never rescues a push.
  assign accept  = in_valid & ready;
  assign do_push = accept & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign drop    = DropWhenFull & accept & full & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = (ovf_q & ~clr_ovf) | drop;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      rdy_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= in_data;
  end

endmodule

// File: rtl/if_axis_mc.sv
// Multi-channel AXI-stream sink exposed to the CPU as a small register block
// with per-channel FIFOs, overflow flags and a maskable level interrupt.
module if_axis_mc
  import if_axis_mc_pkg::*;
#(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned DROP_WHEN_FULL = 1,
  parameter logic [31:0] BASE_ADDR      = 32'hE2000000
) (
  input  logic                           axis_aclk_i,
  input  logic                           axis_aresetn_i,
  input  logic [31:0]                    addr_i,
  input  logic [31:0]                    data_i,
  input  logic                           data_w_i,
  output logic [31:0]                    data_o,
  output logic                           data_access_o,
  output logic                           irq_o,
  input  logic [CHANNELS-1:0]            s_axis_tvalid_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [CHANNELS-1:0]            s_axis_tflag_i,
  output logic [CHANNELS-1:0]            s_axis_tready_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                hit, wr;
  reg_dec_t            dec;
  logic [31:0]         rdata;
  logic [CHANNELS-1:0] mask_q, empty, full, ovf, pop, flush, clr_ovf;
  logic [DATA_WIDTH:0] head  [CHANNELS];
  logic [CntW-1:0]     count [CHANNELS];
  logic                irq_q;
  logic                unused_data;

  assign hit           = (addr_i[31:8] == BASE_ADDR[31:8]);
  assign wr            = hit & data_w_i;
  assign dec           = decode_off(addr_i[7:0]);
  assign data_access_o = hit;
  assign irq_o         = irq_q;
  assign unused_data   = ^{data_i, full};

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign pop[c]     = wr & (dec.sel == RegLevel) & (dec.ch == 5'(c));
    assign flush[c]   = wr & (dec.sel == RegClear) & data_i[c];
    assign clr_ovf[c] = wr & (dec.sel == RegClear) & data_i[OvfBase+c];

    axis_fifo_flag #(
      .Width       (DATA_WIDTH + 1),
      .Depth       (FIFO_DEPTH),
      .DropWhenFull(DROP_WHEN_FULL != 0)
    ) u_fifo (
      .clk     (axis_aclk_i),
      .rst_n   (axis_aresetn_i),
      .in_valid(s_axis_tvalid_i[c]),
      .in_data ({s_axis_tflag_i[c], s_axis_tdata_i[c*DATA_WIDTH +: DATA_WIDTH]}),
      .ready   (s_axis_tready_o[c]),
      .pop     (pop[c]),
      .flush   (flush[c]),
      .clr_ovf (clr_ovf[c]),
      .head    (head[c]),
      .count   (count[c]),
      .full    (full[c]),
      .empty   (empty[c]),
      .ovf     (ovf[c])
    );
  end

  always_comb begin
    rdata = '0;
    case (dec.sel)
      RegStatus: begin
        for (int c = 0; c < CHANNELS; c++) begin
          rdata[c]         = ~empty[c];
          rdata[OvfBase+c] = ovf[c];
        end
      end
      RegMask: rdata[CHANNELS-1:0] = mask_q;
      RegData: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (dec.ch == 5'(c) && !empty[c]) begin
            rdata[DATA_WIDTH-1:0] = head[c][DATA_WIDTH-1:0];
            rdata[FlagBit]        = head[c][DATA_WIDTH];
            rdata[ValidBit]       = 1'b1;
          end
        end
      end
      RegLevel: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (dec.ch == 5'(c)) rdata[CntW-1:0] = count[c];
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
    if (!axis_aresetn_i) begin
      data_o <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (hit && !data_w_i) data_o <= rdata;
      if (wr && dec.sel == RegMask) mask_q <= data_i[CHANNELS-1:0];
      irq_q <= |(mask_q & (~empty | ovf));
    end
  end

endmodule

// File: tb/tb_if_axis_mc.sv
// Directed bench: a drop-on-full instance (A) and a back-pressure instance (B)
// share the CPU bus at different base addresses.
module tb_if_axis_mc;

  localparam logic [31:0] BaseA = 32'hE2000000;
  localparam logic [31:0] BaseB = 32'hE2000100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic        acc_a, acc_b, irq_a, irq_b;
  logic [1:0]  tvalid_a = '0, tflag_a = '0, tready_a;
  logic [1:0]  tvalid_b = '0, tflag_b = '0, tready_b;
  logic [15:0] tdata_a = '0, tdata_b = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_axis_mc #(
    .CHANNELS(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .DROP_WHEN_FULL(1), .BASE_ADDR(BaseA)
  ) dut_a (
    .axis_aclk_i    (clk),
    .axis_aresetn_i (rst_n),
    .addr_i         (addr),
    .data_i         (wdata),
    .data_w_i       (wr),
    .data_o         (rdata_a),
    .data_access_o  (acc_a),
    .irq_o          (irq_a),
    .s_axis_tvalid_i(tvalid_a),
    .s_axis_tdata_i (tdata_a),
    .s_axis_tflag_i (tflag_a),
    .s_axis_tready_o(tready_a)
  );

  if_axis_mc #(
    .CHANNELS(2), .DATA_WIDTH(8), .FIFO_DEPTH(4), .DROP_WHEN_FULL(0), .BASE_ADDR(BaseB)
  ) dut_b (
    .axis_aclk_i    (clk),
    .axis_aresetn_i (rst_n),
    .addr_i         (addr),
    .data_i         (wdata),
    .data_w_i       (wr),
    .data_o         (rdata_b),
    .data_access_o  (acc_b),
    .irq_o          (irq_b),
    .s_axis_tvalid_i(tvalid_b),
    .s_axis_tdata_i (tdata_b),
    .s_axis_tflag_i (tflag_b),
    .s_axis_tready_o(tready_b)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    wr   = 1'b0;
    cyc();
    v    = a[8] ? rdata_b : rdata_a;
    addr = '0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    cyc();
    wr    = 1'b0;
    addr  = '0;
  endtask

  task automatic push_a(input int ch, input logic [7:0] d, input logic f);
    tvalid_a[ch]         = 1'b1;
    tdata_a[ch*8 +: 8]   = d;
    tflag_a[ch]          = f;
    cyc();
    tvalid_a[ch]         = 1'b0;
  endtask

  // Drives a beat on A ch0 while a CPU write happens in the same cycle.
  task automatic push_a0_with_wr(input logic [7:0] d, input logic [31:0] a,
                                 input logic [31:0] wd);
    tvalid_a[0]  = 1'b1;
    tdata_a[7:0] = d;
    tflag_a[0]   = 1'b0;
    addr         = a;
    wdata        = wd;
    wr           = 1'b1;
    cyc();
    tvalid_a[0]  = 1'b0;
    wr           = 1'b0;
    addr         = '0;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  bdata;
    logic        rdy;

    // Reset state
    repeat (2) cyc();
    chk("rst_tready_a", {30'd0, tready_a}, 32'h0);
    chk("rst_tready_b", {30'd0, tready_b}, 32'h0);
    chk("rst_data_o", rdata_a, 32'h0);
    chk("rst_irq", {31'd0, irq_a}, 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("tready_after_rst_a", {30'd0, tready_a}, 32'h3);
    chk("tready_after_rst_b", {30'd0, tready_b}, 32'h3);

    addr = BaseA + 32'h4;
    #1;
    chk("access_hit_a", {31'd0, acc_a}, 32'h1);
    chk("access_miss_b", {31'd0, acc_b}, 32'h0);
    addr = '0;
    rd(BaseA + 32'h00, v); chk("status_idle", v, 32'h0);
    rd(BaseA + 32'h04, v); chk("mask_idle", v, 32'h0);

    // Single beat with flag on ch0
    push_a(0, 8'h1C, 1'b1);
    rd(BaseA + 32'h10, v); chk("data0_1c", v, 32'h8100001C);
    rd(BaseA + 32'h14, v); chk("level0_1", v, 32'h1);
    wr_reg(BaseA + 32'h14, 32'h0);
    rd(BaseA + 32'h10, v); chk("data0_empty", v, 32'h0);
    rd(BaseA + 32'h40, v); chk("unmapped_ch", v, 32'h0);

    // Drop-on-full: six beats into a 4-deep FIFO
    tvalid_a[1] = 1'b1;
    tflag_a[1]  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tdata_a[15:8] = 8'(i);
      cyc();
    end
    tvalid_a[1] = 1'b0;
    rd(BaseA + 32'h1C, v); chk("level1_full", v, 32'h4);
    rd(BaseA + 32'h00, v); chk("status_ovf1", v, 32'h202);
    rd(BaseA + 32'h18, v); chk("data1_head", v, 32'h80000001);
    wr_reg(BaseA + 32'h08, 32'h200);
    rd(BaseA + 32'h00, v); chk("status_ovf1_clr", v, 32'h002);

    // IRQ masking
    wr_reg(BaseA + 32'h08, 32'h2);
    rd(BaseA + 32'h00, v); chk("status_flushed", v, 32'h0);
    push_a(0, 8'h33, 1'b0);
    wr_reg(BaseA + 32'h04, 32'hFFFF_FFF2);
    rd(BaseA + 32'h04, v); chk("mask_rb", v, 32'h2);
    cyc();
    chk("irq_masked", {31'd0, irq_a}, 32'h0);
    push_a(1, 8'h44, 1'b0);
    chk("irq_lat1", {31'd0, irq_a}, 32'h0);
    cyc();
    chk("irq_lat2", {31'd0, irq_a}, 32'h1);
    wr_reg(BaseA + 32'h1C, 32'h0);
    cyc();
    chk("irq_drop", {31'd0, irq_a}, 32'h0);

    // Push+pop at count 2, then drop/clear/flush interactions on ch0
    push_a(0, 8'h34, 1'b0);
    push_a0_with_wr(8'h35, BaseA + 32'h14, 32'h0);
    rd(BaseA + 32'h14, v); chk("level0_pushpop", v, 32'h2);
    rd(BaseA + 32'h10, v); chk("data0_order", v, 32'h80000034);
    wr_reg(BaseA + 32'h08, 32'h1);
    for (int i = 0; i < 4; i++) push_a(0, 8'(8'h40 + i), 1'b0);
    push_a0_with_wr(8'h44, BaseA + 32'h14, 32'h0);
    rd(BaseA + 32'h14, v); chk("level0_full_pop", v, 32'h3);
    rd(BaseA + 32'h10, v); chk("data0_after_pop", v, 32'h80000041);
    rd(BaseA + 32'h00, v); chk("status_drop_pop", v, 32'h101);
    push_a(0, 8'h45, 1'b0);
    push_a0_with_wr(8'h46, BaseA + 32'h08, 32'h100);
    rd(BaseA + 32'h00, v); chk("ovf_clr_vs_drop", v, 32'h101);
    push_a0_with_wr(8'h47, BaseA + 32'h08, 32'h001);
    rd(BaseA + 32'h14, v); chk("level0_flush_push", v, 32'h0);
    rd(BaseA + 32'h00, v); chk("status_flush_push", v, 32'h100);
    wr_reg(BaseA + 32'h08, 32'h100);
    rd(BaseA + 32'h00, v); chk("status_clean", v, 32'h0);

    // Back-pressure instance
    bdata       = 8'd1;
    tvalid_b[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tdata_b[7:0] = bdata;
      rdy = tready_b[0];
      cyc();
      if (rdy) bdata = bdata + 8'd1;
    end
    chk("b_tready_low", {31'd0, tready_b[0]}, 32'h0);
    rd(BaseB + 32'h14, v); chk("b_level_4", v, 32'h4);
    rd(BaseB + 32'h10, v); chk("b_head_1", v, 32'h80000001);
    wr_reg(BaseB + 32'h14, 32'h0);
    chk("b_tready_back", {31'd0, tready_b[0]}, 32'h1);
    cyc();
    tvalid_b[0] = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      rd(BaseB + 32'h10, v); chk("b_order", v, 32'h80000000 | 32'(e));
      wr_reg(BaseB + 32'h14, 32'h0);
    end
    rd(BaseB + 32'h00, v); chk("b_status_empty", v, 32'h0);

    // Asynchronous reset mid-stream
    tvalid_a[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tdata_a[15:8] = 8'(8'h50 + i);
      cyc();
    end
    tvalid_a[1] = 1'b0;
    cyc();
    chk("irq_before_rst", {31'd0, irq_a}, 32'h1);
    rd(BaseA + 32'h1C, v); chk("level1_before_rst", v, 32'h3);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_tready", {30'd0, tready_a}, 32'h0);
    chk("mid_rst_irq", {31'd0, irq_a}, 32'h0);
    chk("mid_rst_data_o", rdata_a, 32'h0);
    cyc();
    chk("mid_rst_tready_held", {30'd0, tready_a}, 32'h0);
    rst_n = 1'b1;
    cyc();
    rd(BaseA + 32'h00, v); chk("post_rst_status", v, 32'h0);
    rd(BaseA + 32'h1C, v); chk("post_rst_level1", v, 32'h0);
    rd(BaseA + 32'h04, v); chk("post_rst_mask", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_axis_mc.md
# if_axis_mc

Multi-channel AXI-stream to CPU bridge, the parametrised successor of the single-channel stream interface. It sits on the processor bus next to the GPIO/UART peripheral block and sinks up to 8 AXI-stream sources (keyboard, switches, future input devices). Each channel is buffered in its own FIFO with per-entry flag capture and an optional drop-on-full mode with a sticky overflow bit. A maskable level interrupt feeds `ext_irq`.

## Interface
- `CHANNELS`, 2: number of stream inputs, 1..8.
- `DATA_WIDTH`, 8: tdata width per channel, 1..24.
- `FIFO_DEPTH`, 16: entries per channel; power of two, 2..256.
- `DROP_WHEN_FULL`, 1: 1 = tready held high and beats arriving while full are dropped; 0 = tready = not full (back-pressure).
- `BASE_ADDR`, 32'hE2000000: block decodes `addr_i[31:8] == BASE_ADDR[31:8]`.

- `axis_aclk_i` in 1: single clock for the whole block.
- `axis_aresetn_i` in 1: reset, asynchronous, active-low.
- `addr_i` in 32: CPU address.
- `data_i` in 32: CPU write data, already byte-swapped at top level.
- `data_w_i` in 1: CPU write strobe, any byte lane.
- `data_o` out 32: registered read data, byte-swapped at top level.
- `data_access_o` out 1: combinational address-decode hit.
- `irq_o` out 1: registered level interrupt.
- `s_axis_tvalid_i` in CHANNELS: per-channel valid.
- `s_axis_tdata_i` in CHANNELS*DATA_WIDTH: channel c occupies `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tflag_i` in CHANNELS: sideband flag, stored with each beat.
- `s_axis_tready_o` out CHANNELS: per-channel ready.

## Operation
- Register map, word offsets from `addr_i[7:0]`:
  - 0x00 STATUS (RO): bit c = FIFO c non-empty; bit 8+c = overflow c (sticky).
  - 0x04 IRQ_MASK (RW): bits [CHANNELS-1:0]. Other bits read 0.
  - 0x08 CLEAR (WO): bit c flushes FIFO c; bit 8+c clears overflow c.
  - 0x10+8c DATA_c (RO): [DATA_WIDTH-1:0] head tdata; [24] head tflag; [31] non-empty. Reads 0 when empty. Side-effect free.
  - 0x14+8c, read LEVEL_c: [8:0] current count. Write POP_c: any write pops one entry if non-empty; ignored when empty.
  - Unmapped offsets and channels ≥ CHANNELS read 0, and writes to them are ignored.
- Push: a beat is accepted when `tvalid & tready` for that channel.
  - DROP_WHEN_FULL=1: when full, the beat is dropped and overflow c is set.
  - DROP_WHEN_FULL=0: overflow is never set.
- Fullness for push is judged on the count at the start of the cycle. A push that arrives while full is dropped even if a pop occurs in the same cycle.
- Push and pop in the same cycle with 0 < count < DEPTH: count unchanged, data ordering preserved.
- Flush with push or pop in the same cycle: flush wins. A concurrent beat is consumed and discarded, and overflow is not set.
- Clearing overflow c in the same cycle as a new drop on c: overflow stays set.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. Count is `$clog2(FIFO_DEPTH)+1` bits.
- `irq_o` = OR over c of IRQ_MASK[c] & (non-empty c | overflow c), registered.

## Timing
- Reset values:
  - `data_o` = 0, `irq_o` = 0, `s_axis_tready_o` = 0.
  - All FIFOs empty, overflow = 0, IRQ_MASK = 0.
- After reset is released, `s_axis_tready_o` goes to all ones on the first clock edge.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and buffered beats are lost.
- Read latency is 1: `data_o` reflects the register addressed in cycle N at cycle N+1 and holds until the next access.
- Writes (mask, clear, pop) take effect at the edge ending the cycle in which `data_access_o & data_w_i`.
- A pushed beat is visible in STATUS and DATA one cycle after acceptance.
- `irq_o` follows the causing state change by one further cycle.
- Back-to-back POP writes pop one entry per cycle.

## Structure
- Shared package `if_axis_mc_pkg` holds:
  - register offset constants (STATUS, IRQ_MASK, CLEAR, DATA/LEVEL stride base 0x10, stride 8);
  - bit positions (VALID=31, FLAG=24, OVF_BASE=8).
- Sub-module `axis_fifo_flag`: one synchronous FIFO of width DATA_WIDTH+1 with push, pop, flush, count, full, empty and drop-overflow. It is instantiated CHANNELS times via generate.
- The top handles address decode, registers, read mux and IRQ.

## Test plan
- Reset, then push 0x1C with flag=1 on ch0 → read 0x10 returns 0x8100001C; LEVEL_0 reads 1; POP_0 then read 0x10 returns 0.
- DROP_WHEN_FULL=1, DEPTH=4: push 6 beats 0x01..0x06 on ch1 → LEVEL_1 reads 4; STATUS bit 9 = 1; head reads 0x01. CLEAR 0x200 clears bit 9.
- DROP_WHEN_FULL=0, DEPTH=4: hold tvalid with 6 beats → tready drops after 4. After one pop, the 5th beat is accepted and the order is 1,2,3,4,5.
- IRQ_MASK=0x2 with data on ch0 only → `irq_o` stays 0. Push on ch1 → `irq_o`=1 two cycles after acceptance. Popping ch1 to empty → `irq_o`=0.
- Simultaneous push+pop at count 2 → count stays 2. Flush+push in the same cycle → count 0, no overflow.
- Assert `axis_aresetn_i` mid-stream with 3 entries buffered → FIFO empty, `irq_o`=0, tready=0 while reset is held.
